// File: rtl/tour_pkg.sv
// Shared constants and types for the knight-tour command replayer.
package tour_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned MOVE_W = 8;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned HEAD_W = 8;
    localparam int unsigned SQ_W   = 4;

    localparam logic [OP_W-1:0] OP_MOVE    = 4'b0010;
    localparam logic [OP_W-1:0] OP_FANFARE = 4'b0011;

    localparam logic [HEAD_W-1:0] HEAD_NORTH = 8'h00;
    localparam logic [HEAD_W-1:0] HEAD_WEST  = 8'h3F;
    localparam logic [HEAD_W-1:0] HEAD_SOUTH = 8'h7F;
    localparam logic [HEAD_W-1:0] HEAD_EAST  = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // Move-bit indices, named by (dx,dy)
    localparam int unsigned MV_E1_N2 = 0;
    localparam int unsigned MV_W1_N2 = 1;
    localparam int unsigned MV_W2_N1 = 2;
    localparam int unsigned MV_W2_S1 = 3;
    localparam int unsigned MV_W1_S2 = 4;
    localparam int unsigned MV_E1_S2 = 5;
    localparam int unsigned MV_E2_S1 = 6;
    localparam int unsigned MV_E2_N1 = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_HOLD_V,
        ST_HORZ,
        ST_HOLD_H
    } state_e;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [OP_W-1:0]   op,
                                                 input logic [HEAD_W-1:0] head,
                                                 input logic [SQ_W-1:0]   sq);
        return {op, head, sq};
    endfunction

endpackage

// File: rtl/tour_move_dec.sv
// Splits a one-hot knight move into its vertical and horizontal robot commands.
module tour_move_dec
    import tour_pkg::*;
(
    input  logic [MOVE_W-1:0] move,
    output logic [CMD_W-1:0]  vert_cmd,
    output logic [CMD_W-1:0]  horz_cmd
);

    logic [HEAD_W-1:0] v_head;
    logic [HEAD_W-1:0] h_head;
    logic [SQ_W-1:0]   v_sq;
    logic [SQ_W-1:0]   h_sq;

    // Anything not exactly one-hot decodes to zero-square no-op commands
    always_comb begin
        v_head = HEAD_NORTH;
        h_head = HEAD_EAST;
        v_sq   = SQ_W'(0);
        h_sq   = SQ_W'(0);
        case (move)
            MOVE_W'(1) << MV_E1_N2: begin v_head = HEAD_NORTH; v_sq = 4'd2; h_head = HEAD_EAST; h_sq = 4'd1; end
            MOVE_W'(1) << MV_W1_N2: begin v_head = HEAD_NORTH; v_sq = 4'd2; h_head = HEAD_WEST; h_sq = 4'd1; end
            MOVE_W'(1) << MV_W2_N1: begin v_head = HEAD_NORTH; v_sq = 4'd1; h_head = HEAD_WEST; h_sq = 4'd2; end
            MOVE_W'(1) << MV_W2_S1: begin v_head = HEAD_SOUTH; v_sq = 4'd1; h_head = HEAD_WEST; h_sq = 4'd2; end
            MOVE_W'(1) << MV_W1_S2: begin v_head = HEAD_SOUTH; v_sq = 4'd2; h_head = HEAD_WEST; h_sq = 4'd1; end
            MOVE_W'(1) << MV_E1_S2: begin v_head = HEAD_SOUTH; v_sq = 4'd2; h_head = HEAD_EAST; h_sq = 4'd1; end
            MOVE_W'(1) << MV_E2_S1: begin v_head = HEAD_SOUTH; v_sq = 4'd1; h_head = HEAD_EAST; h_sq = 4'd2; end
            MOVE_W'(1) << MV_E2_N1: begin v_head = HEAD_NORTH; v_sq = 4'd1; h_head = HEAD_EAST; h_sq = 4'd2; end
            default: ;
        endcase
    end

    assign vert_cmd = mk_cmd(OP_MOVE, v_head, v_sq);
    assign horz_cmd = mk_cmd(OP_FANFARE, h_head, h_sq);

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight tour as robot commands, passing UART commands through when idle.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_tour,
    input  logic [MOVE_W-1:0] move,
    output logic [IDX_W-1:0]  mv_indx,
    input  logic [CMD_W-1:0]  cmd_UART,
    input  logic              cmd_rdy_UART,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic              send_resp,
    output logic [7:0]        resp
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [CMD_W-1:0] vert_cmd;
    logic [CMD_W-1:0] horz_cmd;

    tour_move_dec u_dec (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mv_indx_q <= IDX_W'(0);
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Next-state and move index
    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_tour) begin
                    state_d   = ST_VERT;
                    mv_indx_d = IDX_W'(0);
                end
            end
            ST_VERT:   if (clr_cmd_rdy) state_d = ST_HOLD_V;
            ST_HOLD_V: if (send_resp)   state_d = ST_HORZ;
            ST_HORZ:   if (clr_cmd_rdy) state_d = ST_HOLD_H;
            ST_HOLD_H: begin
                if (send_resp) begin
                    if (mv_indx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_VERT;
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command / response mux on state
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_BUSY;
        case (state_q)
            ST_IDLE: resp = RESP_DONE;
            ST_VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            ST_HOLD_V: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
            end
            ST_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            ST_HOLD_H: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                if (mv_indx_q == LAST_IDX) resp = RESP_DONE;
            end
            default: ;
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized replay bench for tour_cmd against a table-driven knight-move model.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [NUM_MOVES];
    int  dx_tab [8] = '{ 1, -1, -2, -2, -1,  1,  2,  2};
    int  dy_tab [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    int  rise_cnt;
    bit  counting;
    logic rdy_prev;

    tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp)
    );

    always #5 clk = ~clk;

    // Solver memory: read-only table addressed by the DUT
    always_comb move = (mv_indx < 5'(NUM_MOVES)) ? mem[mv_indx] : 8'h00;

    always @(negedge clk) begin
        if (counting && cmd_rdy && !rdy_prev) rise_cnt++;
        rdy_prev <= cmd_rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_onehot(input logic [7:0] m);
        return $countones(m) == 1;
    endfunction

    function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz);
        int d;
        logic [7:0] head;
        d = 0;
        for (int i = 0; i < 8; i++)
            if (m == (8'd1 << i)) d = horiz ? dx_tab[i] : dy_tab[i];
        if (horiz) head = (d > 0) ? 8'hBF : 8'h3F;
        else       head = (d > 0) ? 8'h00 : 8'h7F;
        return {horiz ? 4'h3 : 4'h2, head, 4'((d < 0) ? -d : d)};
    endfunction

    // Compare cmd against model; for invalid moves only opcode and squares are defined
    task automatic check_cmd(input string tag, input logic [7:0] m, input bit horiz);
        logic [15:0] e;
        e = model_cmd(m, horiz);
        if (is_onehot(m)) check(tag, 32'(cmd), 32'(e));
        else check(tag, 32'({cmd[15:12], cmd[3:0]}), 32'({e[15:12], 4'h0}));
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (!cmd_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) check({tag, "_timeout"}, 32'(cmd_rdy), 32'(1));
    endtask

    // Replays one tour; if abort_at >= 0, reset is pulsed in HOLD_H of that move
    task automatic run_tour(input int abort_at);
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        for (int k = 0; k < NUM_MOVES; k++) begin
            wait_rdy("vert_rdy");
            check("vert_idx", 32'(mv_indx), 32'(k));
            check_cmd("vert_cmd", mem[k], 1'b0);
            check("vert_resp", 32'(resp), 32'h5A);
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'b1;
            clr_cmd_rdy  = 1'b1;
            #1;
            check_cmd("vert_ignore_uart", mem[k], 1'b0);
            @(negedge clk);
            clr_cmd_rdy  = 1'b0;
            cmd_rdy_UART = 1'b0;
            check("hold_v_rdy", 32'(cmd_rdy), 32'(0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("hold_v_resp", 32'(resp), 32'h5A);
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
            wait_rdy("horz_rdy");
            check_cmd("horz_cmd", mem[k], 1'b1);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            check("hold_h_rdy", 32'(cmd_rdy), 32'(0));
            check("hold_h_resp", 32'(resp), (k == NUM_MOVES - 1) ? 32'hA5 : 32'h5A);
            if (k == abort_at) begin
                cmd_UART     = 16'h1234;
                cmd_rdy_UART = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_idx", 32'(mv_indx), 32'(0));
                check("rst_resp", 32'(resp), 32'hA5);
                check("rst_pass_cmd", 32'(cmd), 32'h1234);
                check("rst_pass_rdy", 32'(cmd_rdy), 32'(1));
                @(negedge clk);
                rst_n        = 1'b1;
                cmd_rdy_UART = 1'b0;
                return;
            end
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NUM_MOVES; i++) begin
            if ($urandom_range(0, 5) == 0) mem[i] = 8'($urandom);
            else mem[i] = 8'd1 << $urandom_range(0, 7);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        counting     = 1'b0;
        rise_cnt     = 0;
        fill_mem();
        mem[0] = 8'h01;
        mem[1] = 8'h08;
        mem[2] = 8'h03;
        repeat (2) @(negedge clk);
        check("reset_idx", 32'(mv_indx), 32'(0));
        check("reset_resp", 32'(resp), 32'hA5);
        rst_n = 1'b1;

        // Idle pass-through
        cmd_UART = 16'h2004;
        cmd_rdy_UART = 1'b1;
        #1;
        check("idle_cmd", 32'(cmd), 32'h2004);
        check("idle_rdy", 32'(cmd_rdy), 32'(1));
        check("idle_resp", 32'(resp), 32'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            #1;
            check("idle_rand_cmd", 32'(cmd), 32'(cmd_UART));
            check("idle_rand_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
        end
        cmd_rdy_UART = 1'b0;

        // Full tour
        @(negedge clk);
        counting = 1'b1;
        run_tour(-1);
        counting = 1'b0;
        check("rdy_count", 32'(rise_cnt), 32'(2 * NUM_MOVES));
        check("end_resp", 32'(resp), 32'hA5);
        check("end_rdy", 32'(cmd_rdy), 32'(0));
        cmd_UART = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        #1;
        check("end_pass_cmd", 32'(cmd), 32'hBEEF);
        check("end_pass_rdy", 32'(cmd_rdy), 32'(1));
        @(negedge clk);
        cmd_rdy_UART = 1'b0;
        repeat (3) @(negedge clk);
        check("stay_idle_rdy", 32'(cmd_rdy), 32'(0));

        // Second tour aborted by reset at move 10
        fill_mem();
        run_tour(10);
        repeat (2) @(negedge clk);
        check("post_rst_idx", 32'(mv_indx), 32'(0));
        check("post_rst_resp", 32'(resp), 32'hA5);
        cmd_UART = 16'h2004;
        cmd_rdy_UART = 1'b1;
        #1;
        check("post_rst_cmd", 32'(cmd), 32'h2004);
        @(negedge clk);
        cmd_rdy_UART = 1'b0;

        // Third tour runs to completion after the abort
        fill_mem();
        run_tour(-1);
        check("tour3_end_resp", 32'(resp), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter NUM_MOVES, default 24, number of knight moves in a 5x5 tour solution.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start_tour  input  1  single-cycle pulse: solver done, begin replaying solution.
REQ-005 move  input  8  one-hot move read from solver at address mv_indx.
REQ-006 mv_indx  output  5  solution read address, 0..NUM_MOVES-1.
REQ-007 cmd_UART  input  16  command from UART wrapper.
REQ-008 cmd_rdy_UART  input  1  cmd_UART valid.
REQ-009 cmd  output  16  command to robot command processor.
REQ-010 cmd_rdy  output  1  cmd valid.
REQ-011 clr_cmd_rdy  input  1  command processor accepted cmd.
REQ-012 send_resp  input  1  command processor finished executing cmd.
REQ-013 resp  output  8  response byte to UART.

Function
REQ-014 Command format: [15:12] opcode, [11:4] heading, [3:0] squares; tour opcodes 4'b0010 (move) and 4'b0011 (move with fanfare).
REQ-015 Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-016 Move bits (dx,dy): b0(+1,+2) b1(-1,+2) b2(-2,+1) b3(-2,-1) b4(-1,-2) b5(+1,-2) b6(+2,-1) b7(+2,+1).
REQ-017 Each move splits into vertical cmd (opcode 0010, north if dy>0 else south, squares |dy|) then horizontal cmd (opcode 0011, east if dx>0 else west, squares |dx|).
REQ-018 States: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
REQ-019 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART (pass-through); start_tour -> VERT with mv_indx cleared to 0.
REQ-020 VERT: cmd_rdy=1 with vertical cmd; clr_cmd_rdy -> HOLD_V (cmd_rdy drops next cycle).
REQ-021 HOLD_V: cmd_rdy=0; send_resp -> HORZ.
REQ-022 HORZ: cmd_rdy=1 with horizontal cmd; clr_cmd_rdy -> HOLD_H.
REQ-023 HOLD_H: send_resp with mv_indx==NUM_MOVES-1 -> IDLE; send_resp otherwise -> VERT and mv_indx increments.
REQ-024 cmd_UART/cmd_rdy_UART ignored outside IDLE; start_tour ignored outside IDLE.
REQ-025 resp=8'hA5 when in IDLE or (mv_indx==NUM_MOVES-1 and state HOLD_H); else 8'h5A.
REQ-026 move treated as stable while mv_indx constant; non-one-hot move yields squares 0 (no-op cmd), no hang.
REQ-027 mv_indx never exceeds NUM_MOVES-1; no wrap.

Reset
REQ-028 rst_n low forces IDLE, mv_indx=0 immediately, regardless of edge.
REQ-029 Reset mid-tour abandons tour; outputs revert to pass-through, resp=8'hA5.

Structure
REQ-030 Package tour_pkg holds opcode constants, heading constants, state enum, move-bit indices.
REQ-031 One combinational sub-module tour_move_dec: move -> vertical and horizontal cmd words.
REQ-032 Single FSM plus 5-bit index counter; cmd/cmd_rdy via mux on state.

Verification
REQ-033 IDLE, cmd_UART=16'h2004, cmd_rdy_UART=1 -> cmd=16'h2004, cmd_rdy=1 same cycle, resp=8'hA5.
REQ-034 start_tour, move=8'h01 -> cmd=16'h2002 (north 2); after clr_cmd_rdy+send_resp -> cmd=16'h3BF1 (east 1).
REQ-035 move=8'h08 -> vertical 16'h27F1 (south 1), horizontal 16'h33F2 (west 2).
REQ-036 Full 24-move replay -> mv_indx steps 0..23, 48 cmd_rdy assertions, resp=8'h5A for first 47 responses, 8'hA5 on last, return to IDLE.
REQ-037 cmd_rdy_UART pulsed during tour -> cmd unchanged from tour cmd.
REQ-038 rst_n asserted in HOLD_H at mv_indx=10 -> IDLE, mv_indx=0, pass-through resumes.
